tx_arb_req_recorder: RTL

//  Order-preserving request recorder for the TL TX arbiter. Captures per-source TLP-ready requests
//  (several may arrive in one cycle), queues them as source codes in arrival order, and presents the
//  two oldest entries so the arbiter FSM can select TLP1/TLP2 and retire 0, 1 or 2 entries per cycle.

---
 rtl/tx_arb_req_recorder_pkg.sv | 20 ++
 rtl/tx_arb_req_serializer.sv | 34 +++
 rtl/tx_arb_req_recorder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/tx_arb_req_recorder_pkg.sv
// Shared TX arbiter types: source codes, boolean alias, request vector type and recorder defaults.
package tx_arb_req_recorder_pkg;

    localparam int DEFAULT_NUM_SRC = 5;
    localparam int DEFAULT_DEPTH   = 8;

    typedef logic bool_t;

    typedef enum logic [2:0] {
        NO_SOURCE         = 3'd0,
        SRC_A2P_1         = 3'd1,
        SRC_A2P_2         = 3'd2,
        SRC_MASTER        = 3'd3,
        SRC_RX_ROUTER_CFG = 3'd4,
        SRC_RX_ROUTER_ERR = 3'd5
    } source_e;

    typedef logic [DEFAULT_NUM_SRC-1:0] req_type_t;

endpackage

// File: rtl/tx_arb_req_serializer.sv
// Compacts a per-source request mask into an ordered list of source codes (bit 0 first) plus a count.
module tx_arb_req_serializer
    import tx_arb_req_recorder_pkg::*;
#(
    parameter int NUM_SRC = DEFAULT_NUM_SRC,
    parameter int SRC_W   = $clog2(NUM_SRC + 1),
    parameter int N_W     = $clog2(NUM_SRC + 1)
) (
    input  logic [NUM_SRC-1:0]            eff_i,
    output logic [NUM_SRC-1:0][SRC_W-1:0] codes_o,
    output logic [N_W-1:0]                n_o
);

    always_comb begin
        int seen;
        seen = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            codes_o[i] = SRC_W'(NO_SOURCE);
        end
        // Output slot is selected by a constant compare so every index stays static.
        for (int k = 0; k < NUM_SRC; k++) begin
            if (eff_i[k]) begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (i == seen) begin
                        codes_o[i] = SRC_W'(k + 1);
                    end
                end
                seen = seen + 1;
            end
        end
        n_o = N_W'(seen);
    end

endmodule

// File: rtl/tx_arb_req_recorder.sv
// Order-preserving request recorder: queues per-source requests as source codes and exposes the
// two oldest entries to the arbiter, which retires 0, 1 or 2 of them per cycle.
module tx_arb_req_recorder
    import tx_arb_req_recorder_pkg::*;
#(
    parameter int NUM_SRC = DEFAULT_NUM_SRC,
    parameter int SRC_W   = $clog2(NUM_SRC + 1),
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req_i,
    output logic               req_ready_o,
    input  logic [1:0]         pop_i,
    output logic [SRC_W-1:0]   head0_o,
    output logic               head0_vld_o,
    output logic [SRC_W-1:0]   head1_o,
    output logic               head1_vld_o,
    output logic [NUM_SRC-1:0] pending_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               full_o,
    output logic               underflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int N_W   = $clog2(NUM_SRC + 1);

    // Modulo-DEPTH advance; step never exceeds DEPTH, so one wrap correction is enough.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr, input int step);
        int sum;
        sum = int'(ptr) + step;
        if (sum > DEPTH - 1) begin
            sum = sum - DEPTH;
        end
        return PTR_W'(sum);
    endfunction

    logic [SRC_W-1:0]             mem [DEPTH];
    logic [PTR_W-1:0]             rd_ptr;
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr1;
    logic [CNT_W-1:0]             count;
    logic [NUM_SRC-1:0]           pending;
    logic                         underflow;
    logic [NUM_SRC-1:0]           eff;
    logic [NUM_SRC-1:0][SRC_W-1:0] batch_codes;
    logic [N_W-1:0]               batch_n;
    logic                         fits;
    bool_t                        accept;
    logic [1:0]                   pop_req;
    logic [1:0]                   pop_n;
    logic [NUM_SRC-1:0]           pop_clr;

    assign eff = req_i & ~pending;

    tx_arb_req_serializer #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W),
        .N_W     (N_W)
    ) u_serializer (
        .eff_i   (eff),
        .codes_o (batch_codes),
        .n_o     (batch_n)
    );

    // Acceptance looks only at the pre-pop occupancy, keeping pop_i off the ready path.
    assign fits        = (DEPTH - int'(count)) >= int'(batch_n);
    assign req_ready_o = rst & fits;
    assign accept      = req_ready_o;

    assign pop_req = (pop_i == 2'd3) ? 2'd2 : pop_i;
    assign pop_n   = (int'(pop_req) > int'(count)) ? 2'(count) : pop_req;
    assign rd_ptr1 = ptr_add(rd_ptr, 1);

    always_comb begin
        pop_clr = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (pop_n >= 2'd1 && mem[rd_ptr] == SRC_W'(k + 1)) pop_clr[k] = 1'b1;
            if (pop_n == 2'd2 && mem[rd_ptr1] == SRC_W'(k + 1)) pop_clr[k] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            pending   <= '0;
            underflow <= 1'b0;
        end else begin
            rd_ptr    <= ptr_add(rd_ptr, int'(pop_n));
            if (accept) wr_ptr <= ptr_add(wr_ptr, int'(batch_n));
            count     <= count - CNT_W'(pop_n) + (accept ? CNT_W'(batch_n) : CNT_W'(0));
            pending   <= (pending & ~pop_clr) | (accept ? eff : '0);
            underflow <= int'(pop_req) > int'(count);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (i < int'(batch_n)) mem[ptr_add(wr_ptr, i)] <= batch_codes[i];
            end
        end
    end

    assign head0_vld_o = (count != '0);
    assign head1_vld_o = (int'(count) >= 2);
    assign head0_o     = head0_vld_o ? mem[rd_ptr] : '0;
    assign head1_o     = head1_vld_o ? mem[rd_ptr1] : '0;
    assign pending_o   = pending;
    assign count_o     = count;
    assign full_o      = (count == CNT_W'(DEPTH));
    assign underflow_o = underflow;

    a_occupancy: assert property (@(posedge clk) disable iff (!rst)
        (CNT_W'($countones(pending)) == count) && (count <= CNT_W'(DEPTH)));

endmodule
